// File: rtl/mem_pkg.sv
// mem_pkg
// Shared types and constants for the data-memory access controller and the
// load alignment logic.
//   mem_size_e  : access size encoding as carried on cpu_size
//   mem_state_e : controller FSM state encoding
//   BYTE_LANES  : number of byte lanes on the 32-bit data bus
//   lane_be()   : byte-enable pattern for a given size and lane offset
package mem_pkg;

    localparam int BYTE_LANES = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } mem_state_e;

    // Offset is expected to already be aligned to the access size.
    function automatic logic [BYTE_LANES-1:0] lane_be(input mem_size_e size,
                                                      input logic [1:0] off);
        logic [BYTE_LANES-1:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << off;
            SIZE_HALF: be = 4'b0011 << off;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align
// Combinational load-data alignment: shifts the addressed bytes down to bit 0,
// masks to the access size and sign- or zero-extends. Shared with the
// instruction-fetch path.
// Ports:
//   rdata       in  raw 32-bit word from memory
//   off         in  byte offset of the access within the word
//   size        in  access size (reserved encoding behaves as word)
//   is_unsigned in  1 = zero-extend, 0 = sign-extend
//   data        out aligned, extended result
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  mem_size_e   size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        case (size)
            SIZE_BYTE: data = is_unsigned ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_HALF: data = is_unsigned ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default:   data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Drives the data-memory bus for the load/store stage. Stores become
// byte-enabled write requests; load responses are aligned, extended and
// written into the memory buffer register via mbr_wr_en / mbr_data.
//
// Optional build macro: MEM_ACCESS_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses are never issued; they finish
//               immediately with misalign_err pulsed alongside done.
//   undefined : misaligned low address bits are dropped and the access runs.
//
// Ports:
//   clk, async_rst_n, clk_en           clock, async active-low reset, enable
//   cpu_valid/cpu_ready, cpu_we, cpu_size, cpu_unsigned, cpu_addr,
//   cpu_wdata, cpu_rd                  request from the execute stage
//   mem_req_*                          registered memory request
//   mem_resp_valid, mem_resp_rdata     read response (only used in WAIT)
//   mbr_wr_en, mbr_data                buffer register write port
//   wb_rd, done, busy                  completion and status
//   misalign_err                       (macro builds only) trap flag
//
// state | meaning
// IDLE  | ready for a new request
// REQ   | memory request presented, waiting for mem_req_ready
// WAIT  | read issued, waiting for mem_resp_valid
// DONE  | completion pulse (and buffer write for loads)
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      async_rst_n,
    input  logic                      clk_en,
    input  logic                      cpu_valid,
    output logic                      cpu_ready,
    input  logic                      cpu_we,
    input  logic [1:0]                cpu_size,
    input  logic                      cpu_unsigned,
    input  logic [MEM_ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]     cpu_wdata,
    input  logic [REG_ADDR_WIDTH-1:0] cpu_rd,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0]     mem_req_wdata,
    output logic [BYTE_LANES-1:0]     mem_req_be,
    input  logic                      mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_resp_rdata,
    output logic                      mbr_wr_en,
    output logic [DATA_WIDTH-1:0]     mbr_data,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic                      done,
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    output logic                      misalign_err,
`endif
    output logic                      busy
);

    mem_state_e                state_q, state_d;
    logic                      we_q, we_d;
    mem_size_e                 size_q, size_d;
    logic                      uns_q, uns_d;
    logic [1:0]                off_q, off_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;

    logic                      req_valid_q, req_valid_d;
    logic                      req_we_q, req_we_d;
    logic [MEM_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0]     req_wdata_q, req_wdata_d;
    logic [BYTE_LANES-1:0]     req_be_q, req_be_d;
    logic                      mbr_wr_en_q, mbr_wr_en_d;
    logic [DATA_WIDTH-1:0]     mbr_data_q, mbr_data_d;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic                      done_q, done_d;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic                      misalign_err_q, misalign_err_d;
    logic                      in_misaligned;
`endif

    mem_size_e                 in_size;
    logic [1:0]                in_off;
    logic [BYTE_LANES-1:0]     in_be;
    logic [DATA_WIDTH-1:0]     in_wdata;
    logic [DATA_WIDTH-1:0]     align_data;

    // Request decode. The offset is forced to the size alignment so that in
    // the non-trapping build a misaligned access simply hits the aligned lanes.
    always_comb begin
        case (cpu_size)
            2'b00:   in_size = SIZE_BYTE;
            2'b01:   in_size = SIZE_HALF;
            default: in_size = SIZE_WORD;
        endcase
        case (in_size)
            SIZE_BYTE: in_off = cpu_addr[1:0];
            SIZE_HALF: in_off = {cpu_addr[1], 1'b0};
            default:   in_off = 2'b00;
        endcase
        case (in_size)
            SIZE_BYTE: in_wdata = {4{cpu_wdata[7:0]}};
            SIZE_HALF: in_wdata = {2{cpu_wdata[15:0]}};
            default:   in_wdata = cpu_wdata;
        endcase
        in_be = lane_be(in_size, in_off);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        in_misaligned = ((in_size == SIZE_HALF) && cpu_addr[0]) ||
                        ((in_size == SIZE_WORD) && (cpu_addr[1:0] != 2'b00));
`endif
    end

    mem_load_align u_load_align (
        .rdata       (mem_resp_rdata),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (align_data)
    );

    // With clk_en low every _d equals its _q, which freezes the block and
    // stretches a DONE pulse until the next enabled cycle.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        rd_d        = rd_q;
        req_valid_d = req_valid_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_be_d    = req_be_q;
        mbr_wr_en_d = mbr_wr_en_q;
        mbr_data_d  = mbr_data_q;
        wb_rd_d     = wb_rd_q;
        done_d      = done_q;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        misalign_err_d = misalign_err_q;
`endif
        if (clk_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_valid) begin
                        we_d   = cpu_we;
                        size_d = in_size;
                        uns_d  = cpu_unsigned;
                        off_d  = in_off;
                        rd_d   = cpu_rd;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                        if (in_misaligned) begin
                            state_d        = ST_DONE;
                            done_d         = 1'b1;
                            misalign_err_d = 1'b1;
                            wb_rd_d        = cpu_rd;
                        end else begin
`endif
                            state_d     = ST_REQ;
                            req_valid_d = 1'b1;
                            req_we_d    = cpu_we;
                            req_addr_d  = {cpu_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
                            req_wdata_d = in_wdata;
                            req_be_d    = in_be;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                        end
`endif
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        req_valid_d = 1'b0;
                        if (we_q) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            wb_rd_d = rd_q;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        mbr_wr_en_d = 1'b1;
                        mbr_data_d  = align_data;
                        wb_rd_d     = rd_q;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b0;
                    mbr_wr_en_d = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                    misalign_err_d = 1'b0;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= SIZE_BYTE;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            rd_q        <= '0;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            mbr_wr_en_q <= 1'b0;
            mbr_data_q  <= '0;
            wb_rd_q     <= '0;
            done_q      <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            misalign_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            req_valid_q <= req_valid_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_be_q    <= req_be_d;
            mbr_wr_en_q <= mbr_wr_en_d;
            mbr_data_q  <= mbr_data_d;
            wb_rd_q     <= wb_rd_d;
            done_q      <= done_d;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            misalign_err_q <= misalign_err_d;
`endif
        end
    end

    assign cpu_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign mem_req_valid = req_valid_q;
    assign mem_req_we    = req_we_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_be    = req_be_q;
    assign mbr_wr_en     = mbr_wr_en_q;
    assign mbr_data      = mbr_data_q;
    assign wb_rd         = wb_rd_q;
    assign done          = done_q;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign misalign_err  = misalign_err_q;
`endif

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory access controller that drives the data-memory bus on behalf of the CPU load/store stage. Stores become byte-enabled write requests. Load responses are aligned, extended and written into the memory buffer register through its write port (`mbr_wr_en` / `mbr_data`). It sits between the execute stage and the data-memory port, on the memory side of the buffer register.

## Interface
- `DATA_WIDTH`, 32, data bus width; only 32 is supported (4 byte lanes).
- `MEM_ADDR_WIDTH`, 32, byte-address width.
- `REG_ADDR_WIDTH`, 5, destination register index width.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `async_rst_n`  in  1  reset; asynchronous, active-low.
- `clk_en`  in  1  all state and handshakes advance only when high.
- `cpu_valid` / `cpu_ready`  in / out  1  request handshake; `cpu_ready` is high only in IDLE.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_size`  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `cpu_unsigned`  in  1  zero-extend load when high.
- `cpu_addr`  in  MEM_ADDR_WIDTH  byte address.
- `cpu_wdata`  in  DATA_WIDTH  store data, LSB-justified.
- `cpu_rd`  in  REG_ADDR_WIDTH  load destination register.
- `mem_req_valid` / `mem_req_ready`  out / in  1  memory request handshake.
- `mem_req_we`  out  1  request is a write.
- `mem_req_addr`  out  MEM_ADDR_WIDTH  word-aligned address (low 2 bits = 0).
- `mem_req_wdata`  out  DATA_WIDTH  store data placed on its byte lanes.
- `mem_req_be`  out  4  byte enables.
- `mem_resp_valid` / `mem_resp_rdata`  in / in  1 / DATA_WIDTH  read response; sampled only in WAIT.
- `mbr_wr_en`  out  1  one-cycle write strobe to the buffer register.
- `mbr_data`  out  DATA_WIDTH  extended load data.
- `wb_rd`  out  REG_ADDR_WIDTH  destination register, valid with `done`.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states and transitions:
  - IDLE: on `cpu_valid` and `clk_en`, capture the request → REQ.
  - REQ: hold the `mem_req_*` outputs stable until `mem_req_ready` is sampled with `clk_en`. A store then goes → DONE; a load goes → WAIT.
  - WAIT: on `mem_resp_valid` and `clk_en`, capture the response → DONE.
  - DONE: pulse `done`; for a load also pulse `mbr_wr_en`; → IDLE.
- Byte lanes are little-endian; `off` = `addr[1:0]`.
  - Byte: `be = 1 << off`.
  - Half: `be = 3 << off`.
  - Word: `be = 4'hF`.
- Store data is replicated across lanes: byte ×4, half ×2, word as-is.
- Load data: shift `mem_resp_rdata` right by 8·`off`, mask to the access size, then sign-extend unless `cpu_unsigned`.
- A response arriving outside WAIT is ignored. `cpu_valid` outside IDLE is ignored.
- Reset, including mid-operation: FSM → IDLE and all outputs go to 0. Any outstanding response is dropped.
- `clk_en` low freezes all state. Outputs hold their values; a DONE pulse stretches until the enabled cycle.

## Timing
- Load, zero-wait memory: accept at cycle 0, REQ at cycle 1, WAIT at cycle 2, DONE at cycle 3. `mbr_data` is valid in the cycle `mbr_wr_en` is high.
- Store, zero-wait memory: accept at cycle 0, REQ at cycle 1, DONE at cycle 2.
- At most one outstanding access. The next accept is the cycle after DONE.
- Request and response outputs are registered. `cpu_ready` is decoded from the state register.

## Configuration
- `MEM_ACCESS_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses (half with `off[0]` = 1, word with `off` ≠ 0) are detected in IDLE and never issued.
  - The FSM goes straight to DONE with `misalign_err` = 1 and `mbr_wr_en` = 0.
  - Adds port `misalign_err`  out  1, pulsed with `done`.
- Undefined: the offending low address bits are forced to 0 (half uses `off & 2`, word uses offset 0) and the access proceeds. No extra port.

## Structure
- Package `mem_pkg` holds:
  - the `mem_size_e` enum;
  - the `mem_state_e` FSM enum;
  - the `BYTE_LANES` constant (= 4).
- Sub-module `mem_load_align` holds the combinational shift, mask and extend logic. It is reusable by the instruction-fetch path.

## Test plan
- Load word at 0x100, `rdata` = 0xDEADBEEF, `mem_req_ready` = 1 → `be` = F, `mbr_data` = 0xDEADBEEF, `done` and `mbr_wr_en` at cycle 3.
- Load signed byte at 0x103, `rdata` = 0x80112233 → `mbr_data` = 0xFFFFFF80; same access unsigned → 0x00000080.
- Store half 0xABCD at 0x202 → `mem_req_addr` = 0x200, `be` = 4'b1100, `wdata` = 0xABCDABCD, `done` at cycle 2.
- `mem_req_ready` held low 3 cycles → request outputs stable throughout; `done` delayed 3 cycles; spurious `mem_resp_valid` during REQ ignored.
- Reset asserted in WAIT → all outputs 0 immediately; late response produces no `mbr_wr_en`.
- Word load at 0x101: with macro → `misalign_err` and `done` pulse, no `mem_req_valid`; without macro → `mem_req_addr` = 0x100, `be` = F.
